// File: rtl/pc_halt_dump_ctrl_if.sv
// rtl/pc_halt_dump_ctrl_if.sv - signal bundle for the halt/dump controller
//
// Groups the fetch-PC watch inputs, the req/ack memory read port, the
// valid/ready dump stream and the sticky status flags.
//   master : the controller side (drives rd_req/rd_addr, dump stream, status)
//   slave  : the environment side (drives pc, rd_ack/rd_data, dump_ready)
interface pc_halt_dump_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] pc;
  logic              pc_valid;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic [DATA_W-1:0] rd_data;
  logic              dump_valid;
  logic              dump_ready;
  logic [DATA_W-1:0] dump_data;
  logic [15:0]       dump_index;
  logic              dump_eol;
  logic              halted;
  logic              timed_out;
  logic              done;

  modport master (
    input  pc, pc_valid, rd_ack, rd_data, dump_ready,
    output rd_req, rd_addr, dump_valid, dump_data, dump_index, dump_eol,
           halted, timed_out, done
  );

  modport slave (
    output pc, pc_valid, rd_ack, rd_data, dump_ready,
    input  rd_req, rd_addr, dump_valid, dump_data, dump_index, dump_eol,
           halted, timed_out, done
  );
endinterface

// File: rtl/pc_halt_dump_ctrl.sv
// rtl/pc_halt_dump_ctrl.sv - end-of-program halt detector and memory dump streamer
//
// Watches the fetch PC for END_PC held over STABLE_CYC qualified cycles (or a
// RUN-cycle timeout), then reads DUMP_WORDS words starting at DUMP_BASE one
// at a time over the req/ack port and streams each out on the dump port.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous, active-low
//   bus    : pc_halt_dump_ctrl_if.master
//            in  pc, pc_valid, rd_ack, rd_data, dump_ready
//            out rd_req, rd_addr, dump_valid, dump_data, dump_index,
//                dump_eol, halted, timed_out, done
module pc_halt_dump_ctrl #(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter logic [ADDR_W-1:0] END_PC         = ADDR_W'('h80),
  parameter int unsigned       STABLE_CYC     = 1,
  parameter logic [ADDR_W-1:0] DUMP_BASE      = ADDR_W'(32),
  parameter int unsigned       DUMP_WORDS     = 96,
  parameter int unsigned       WORDS_PER_LINE = 16,
  parameter int unsigned       TIMEOUT        = 100000
) (
  input logic                 clk,
  input logic                 reset,
  pc_halt_dump_ctrl_if.master bus
);

  typedef enum logic [2:0] {RUN, REQ, WAIT, EMIT, DONE} state_t;

  state_t            state, state_n;
  logic [31:0]       match_cnt;
  logic [31:0]       cyc_cnt;
  logic [15:0]       idx;
  logic [15:0]       line_cnt;
  logic [DATA_W-1:0] data_q;
  logic              halted_q;
  logic              timed_out_q;

  logic pc_hit, match_done, time_hit, last_word, reading, emitting;

  assign pc_hit     = bus.pc_valid && (bus.pc == END_PC);
  // match_cnt still holds the count before this cycle, so this cycle is the
  // STABLE_CYC-th match when the count already equals STABLE_CYC-1.
  assign match_done = pc_hit && (match_cnt == 32'(STABLE_CYC - 1));
  assign time_hit   = (TIMEOUT != 0) && (cyc_cnt == 32'(TIMEOUT - 1));
  assign last_word  = (32'(idx) == 32'(DUMP_WORDS - 1));
  assign reading    = (state == REQ) || (state == WAIT);
  assign emitting   = (state == EMIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      RUN:       if (match_done || time_hit) state_n = (DUMP_WORDS == 0) ? DONE : REQ;
      REQ, WAIT: state_n = bus.rd_ack ? EMIT : WAIT;
      EMIT:      if (bus.dump_ready) state_n = last_word ? DONE : REQ;
      DONE:      state_n = DONE;
      default:   state_n = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      match_cnt   <= '0;
      cyc_cnt     <= '0;
      idx         <= '0;
      line_cnt    <= '0;
      data_q      <= '0;
      halted_q    <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          cyc_cnt <= cyc_cnt + 32'd1;
          // A stalled/bubble cycle neither extends nor breaks the streak.
          if (bus.pc_valid) match_cnt <= pc_hit ? match_cnt + 32'd1 : '0;
          if (match_done || time_hit) begin
            halted_q    <= 1'b1;
            timed_out_q <= !match_done;
          end
        end
        REQ, WAIT: if (bus.rd_ack) data_q <= bus.rd_data;
        EMIT: if (bus.dump_ready) begin
          idx      <= idx + 16'd1;
          line_cnt <= (line_cnt == 16'(WORDS_PER_LINE - 1)) ? 16'd0 : line_cnt + 16'd1;
        end
        default: ;
      endcase
    end
  end

  // Data-carrying outputs are forced to zero outside their phase so nothing
  // stale is visible after reset or between words.
  assign bus.rd_req     = reading;
  assign bus.rd_addr    = reading ? DUMP_BASE + ADDR_W'(idx) : '0;
  assign bus.dump_valid = emitting;
  assign bus.dump_data  = emitting ? data_q : '0;
  assign bus.dump_index = emitting ? idx : 16'd0;
  assign bus.dump_eol   = emitting && ((line_cnt == 16'(WORDS_PER_LINE - 1)) || last_word);
  assign bus.halted     = halted_q;
  assign bus.timed_out  = timed_out_q;
  assign bus.done       = (state == DONE);

endmodule

// File: tb/tb_pc_halt_dump_ctrl.sv
// tb/tb_pc_halt_dump_ctrl.sv - self-checking bench for pc_halt_dump_ctrl
`timescale 1ns/1ps
module tb_pc_halt_dump_ctrl;
  localparam int N = 5;
  // Instance order in each vector: {inst4, inst3, inst2, inst1, inst0}
  //   inst0 defaults, inst1 STABLE_CYC=3, inst2 TIMEOUT=200,
  //   inst3 DUMP_WORDS=0, inst4 wrapping base with match/timeout collision
  localparam logic [N-1:0][31:0] P_STABLE  = {32'd1, 32'd1, 32'd1, 32'd3, 32'd1};
  localparam logic [N-1:0][31:0] P_BASE    = {32'hFFFF_FFFE, 32'd32, 32'd32, 32'd32, 32'd32};
  localparam logic [N-1:0][31:0] P_WORDS   = {32'd4, 32'd0, 32'd20, 32'd8, 32'd96};
  localparam logic [N-1:0][31:0] P_WPL     = {32'd3, 32'd16, 32'd6, 32'd16, 32'd16};
  localparam logic [N-1:0][31:0] P_TIMEOUT = {32'd4, 32'd100000, 32'd200, 32'd100000, 32'd100000};
  localparam logic [N-1:0][31:0] HALT_TICK = {32'd3, 32'd5, 32'd199, 32'd16, 32'd50};
  localparam logic [N-1:0]       TO_EXP    = 5'b00100;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] pc [N];
  logic        pc_valid [N];
  logic        rd_ack [N];
  logic [31:0] rd_data [N];
  logic        dump_ready [N];
  logic        rd_req_o [N];
  logic [31:0] rd_addr_o [N];
  logic        dump_valid_o [N];
  logic [31:0] dump_data_o [N];
  logic [15:0] dump_index_o [N];
  logic        dump_eol_o [N];
  logic        halted_o [N];
  logic        timed_out_o [N];
  logic        done_o [N];

  for (genvar g = 0; g < N; g++) begin : g_inst
    pc_halt_dump_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    pc_halt_dump_ctrl #(
      .ADDR_W(32), .DATA_W(32), .END_PC(32'h80),
      .STABLE_CYC(P_STABLE[g]), .DUMP_BASE(P_BASE[g]), .DUMP_WORDS(P_WORDS[g]),
      .WORDS_PER_LINE(P_WPL[g]), .TIMEOUT(P_TIMEOUT[g])
    ) u_dut (.clk(clk), .reset(reset), .bus(bus));
    assign bus.pc          = pc[g];
    assign bus.pc_valid    = pc_valid[g];
    assign bus.rd_ack      = rd_ack[g];
    assign bus.rd_data     = rd_data[g];
    assign bus.dump_ready  = dump_ready[g];
    assign rd_req_o[g]     = bus.rd_req;
    assign rd_addr_o[g]    = bus.rd_addr;
    assign dump_valid_o[g] = bus.dump_valid;
    assign dump_data_o[g]  = bus.dump_data;
    assign dump_index_o[g] = bus.dump_index;
    assign dump_eol_o[g]   = bus.dump_eol;
    assign halted_o[g]     = bus.halted;
    assign timed_out_o[g]  = bus.timed_out;
    assign done_o[g]       = bus.done;
  end

  int n_checks = 0;
  int n_fail = 0;
  int tick = 0;

  // Model: phase 0 running, 1 reading word k, 2 offering word k, 3 finished.
  int          m_phase [N];
  int unsigned m_streak [N];
  int unsigned m_cyc [N];
  int unsigned m_k [N];
  bit          m_halt [N];
  bit          m_to [N];

  bit pend [N];
  int wcnt [N];
  int dly [N];
  int xfer [N];
  int halt_tick [N];
  int done_tick [N];
  logic [31:0] wrap_tab [4];

  task automatic chk(input int i, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL inst%0d %s tick %0d: got %h, expected %h", i, name, tick, act, exp);
    end
  endtask

  // pc seen by instance i at the t-th rising edge after reset release
  task automatic drive_pc(input int i, input int t);
    pc_valid[i] = 1'b1;
    case (i)
      0: pc[i] = (t >= 50) ? 32'h80 : 32'h1000 + 32'(4 * t);
      1: begin
        if (t == 12) pc[i] = 32'h84;
        else if (t == 10 || t == 11 || t >= 13) pc[i] = 32'h80;
        else pc[i] = 32'h40;
        if (t == 14) pc_valid[i] = 1'b0;
      end
      2: pc[i] = 32'h200;
      3: pc[i] = (t >= 5) ? 32'h80 : 32'h10;
      default: pc[i] = (t >= 3) ? 32'h80 : 32'h20;
    endcase
  endtask

  task automatic model_step(input int i);
    bit hit, to;
    case (m_phase[i])
      0: begin
        if (pc_valid[i]) m_streak[i] = (pc[i] == 32'h80) ? m_streak[i] + 1 : 0;
        hit = pc_valid[i] && (pc[i] == 32'h80) && (m_streak[i] >= P_STABLE[i]);
        to  = (P_TIMEOUT[i] != 0) && (m_cyc[i] + 1 == P_TIMEOUT[i]);
        m_cyc[i]++;
        if (hit || to) begin
          m_halt[i]  = 1'b1;
          m_to[i]    = !hit;
          m_phase[i] = (P_WORDS[i] == 0) ? 3 : 1;
        end
      end
      1: if (rd_ack[i]) m_phase[i] = 2;
      2: if (dump_ready[i]) begin
        m_k[i]++;
        m_phase[i] = (m_k[i] == P_WORDS[i]) ? 3 : 1;
      end
      default: ;
    endcase
  endtask

  task automatic compare(input int i);
    bit er, ev, ee;
    logic [31:0] ea, ed, ex;
    er = (m_phase[i] == 1);
    ev = (m_phase[i] == 2);
    ea = er ? P_BASE[i] + m_k[i] : 32'd0;
    ed = ev ? P_BASE[i] + m_k[i] - 32'd32 : 32'd0;
    ex = ev ? m_k[i] : 32'd0;
    ee = ev && ((((m_k[i] + 1) % P_WPL[i]) == 0) || (m_k[i] + 1 == P_WORDS[i]));
    chk(i, "rd_req", 32'(rd_req_o[i]), 32'(er));
    chk(i, "rd_addr", rd_addr_o[i], ea);
    chk(i, "dump_valid", 32'(dump_valid_o[i]), 32'(ev));
    chk(i, "dump_data", dump_data_o[i], ed);
    chk(i, "dump_index", 32'(dump_index_o[i]), ex);
    chk(i, "dump_eol", 32'(dump_eol_o[i]), 32'(ee));
    chk(i, "halted", 32'(halted_o[i]), 32'(m_halt[i]));
    chk(i, "timed_out", 32'(timed_out_o[i]), 32'(m_to[i]));
    chk(i, "done", 32'(done_o[i]), 32'(m_phase[i] == 3));
    // memory holds mem[32+k] = k, so default instance word k carries k
    if (i == 0 && ev) chk(i, "pin_data", dump_data_o[i], m_k[i]);
    if (i == 4 && er && m_k[i] < 4) chk(i, "pin_wrap_addr", rd_addr_o[i], wrap_tab[m_k[i]]);
    if (halted_o[i] === 1'b1 && halt_tick[i] < 0) halt_tick[i] = tick;
    if (done_o[i] === 1'b1 && done_tick[i] < 0) done_tick[i] = tick;
  endtask

  task automatic respond(input int i, input bit rnd);
    if (rd_req_o[i] === 1'b1) begin
      if (!pend[i]) begin
        pend[i] = 1'b1;
        wcnt[i] = 0;
        dly[i]  = rnd ? int'($urandom_range(0, 5)) : 0;
      end else begin
        wcnt[i]++;
      end
      if (wcnt[i] == dly[i]) begin
        rd_ack[i]  = 1'b1;
        rd_data[i] = rd_addr_o[i] - 32'd32;
        pend[i]    = 1'b0;
      end else begin
        rd_ack[i]  = 1'b0;
        rd_data[i] = $urandom;
      end
    end else begin
      pend[i]    = 1'b0;
      rd_ack[i]  = rnd && ($urandom_range(0, 3) == 0);
      rd_data[i] = 32'hBAD0_0000 | 32'($urandom_range(0, 255));
    end
    dump_ready[i] = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
  endtask

  task automatic check_zero(input int i);
    chk(i, "arst_rd_req", 32'(rd_req_o[i]), 32'd0);
    chk(i, "arst_rd_addr", rd_addr_o[i], 32'd0);
    chk(i, "arst_dump_valid", 32'(dump_valid_o[i]), 32'd0);
    chk(i, "arst_dump_data", dump_data_o[i], 32'd0);
    chk(i, "arst_dump_index", 32'(dump_index_o[i]), 32'd0);
    chk(i, "arst_dump_eol", 32'(dump_eol_o[i]), 32'd0);
    chk(i, "arst_halted", 32'(halted_o[i]), 32'd0);
    chk(i, "arst_timed_out", 32'(timed_out_o[i]), 32'd0);
    chk(i, "arst_done", 32'(done_o[i]), 32'd0);
  endtask

  task automatic run_phase(input bit rnd, input bit abort40);
    bit all_done, aborted;
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_phase[i] = 0; m_streak[i] = 0; m_cyc[i] = 0; m_k[i] = 0;
      m_halt[i] = 1'b0; m_to[i] = 1'b0;
      pend[i] = 1'b0; wcnt[i] = 0; dly[i] = 0; xfer[i] = 0;
      halt_tick[i] = -1; done_tick[i] = -1;
      rd_ack[i] = 1'b0; rd_data[i] = 32'd0; dump_ready[i] = 1'b1;
      drive_pc(i, 0);
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) compare(i);
    @(negedge clk);
    reset = 1'b1;
    tick = 0;
    aborted = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      all_done = 1'b1;
      for (int i = 0; i < N; i++) begin
        model_step(i);
        compare(i);
        if (m_phase[i] != 3) all_done = 1'b0;
      end
      if (abort40 && m_phase[0] == 2 && m_k[0] == 40) begin
        // park on word 40, then drop reset between clock edges
        dump_ready[0] = 1'b0;
        #7 reset = 1'b0;
        #1;
        for (int i = 0; i < N; i++) check_zero(i);
        aborted = 1'b1;
        break;
      end
      if (all_done) break;
      for (int i = 0; i < N; i++) begin
        drive_pc(i, tick + 1);
        respond(i, rnd);
        if (dump_valid_o[i] === 1'b1 && dump_ready[i]) begin
          chk(i, "seq_index", 32'(dump_index_o[i]), xfer[i]);
          xfer[i]++;
        end
      end
      tick++;
    end
    if (!aborted) begin
      for (int i = 0; i < N; i++) begin
        chk(i, "end_done", 32'(done_o[i]), 32'd1);
        chk(i, "end_words", xfer[i], P_WORDS[i]);
        chk(i, "halt_tick", halt_tick[i], HALT_TICK[i]);
        chk(i, "end_timed_out", 32'(timed_out_o[i]), 32'(TO_EXP[i]));
      end
      if (!rnd) begin
        chk(0, "done_tick", done_tick[0], 32'd242);
        chk(3, "done_tick", done_tick[3], 32'd5);
      end
    end
  endtask

  initial begin
    wrap_tab[0] = 32'hFFFF_FFFE;
    wrap_tab[1] = 32'hFFFF_FFFF;
    wrap_tab[2] = 32'h0000_0000;
    wrap_tab[3] = 32'h0000_0001;
    run_phase(1'b0, 1'b0);
    run_phase(1'b1, 1'b0);
    run_phase(1'b0, 1'b1);
    run_phase(1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
